// File: rtl/sdram_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// sdram_cmd_sequencer
//
// Purpose: command sequencer between the i386 bus-side 9-bit row/column
// address latches and an SDRAM device. After reset it runs the power-up
// init sequence: NOPs, PRECHARGE-all, two AUTO-REFRESH commands and MODE
// REGISTER SET. It then serves single-beat read/write accesses
// (LATCH, ACTIVATE, READ/WRITE, PRECHARGE) and periodic auto-refresh.
//
// Optional feature macro: SDRAM_AUTOPRE_EN. When it is defined, READ/WRITE
// are issued with auto-precharge and no separate PRECHARGE is sent.
//
// Ports:
//   clk_i          system clock, rising edge
//   reset_i        synchronous active-high reset
//   req_i          access request (level), sampled only at the arbitration point
//   we_req_i       1 = write, 0 = read, sampled with req_i
//   row_q_i        row address from the row latch output
//   col_q_i        column address from the column latch output
//   lat_g_o        latch capture strobe, one cycle in LATCH
//   lat_oe_n_o     latch output enable, active low once init is done
//   sd_cs_n_o, sd_ras_n_o, sd_cas_n_o, sd_we_n_o   SDRAM command pins
//   sd_a_o         SDRAM address
//   sd_ap_o        A10: auto-precharge / precharge-all
//   ready_o        one-cycle access-complete pulse
//   busy_o         high in every state except IDLE
//   init_done_o    high once the init sequence has completed
// ---------------------------------------------------------------------------
module sdram_cmd_sequencer #(
  parameter int unsigned INIT_CYCLES  = 100,
  parameter int unsigned T_RCD        = 2,
  parameter int unsigned CAS_LAT      = 2,
  parameter int unsigned T_WR         = 2,
  parameter int unsigned T_RP         = 2,
  parameter int unsigned T_RFC        = 7,
  parameter int unsigned REF_INTERVAL = 780
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       req_i,
  input  logic       we_req_i,
  input  logic [8:0] row_q_i,
  input  logic [8:0] col_q_i,
  output logic       lat_g_o,
  output logic       lat_oe_n_o,
  output logic       sd_cs_n_o,
  output logic       sd_ras_n_o,
  output logic       sd_cas_n_o,
  output logic       sd_we_n_o,
  output logic [8:0] sd_a_o,
  output logic       sd_ap_o,
  output logic       ready_o,
  output logic       busy_o,
  output logic       init_done_o
);

  // Command encodings {CS_N, RAS_N, CAS_N, WE_N}
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;
  localparam logic [3:0] CMD_DESEL = 4'b1111;

  // Each command state stays for (load + 1) cycles: the command in the
  // first cycle and NOPs while the wait counter runs down to zero.
  localparam logic [15:0] INIT_LOAD = 16'(INIT_CYCLES - 1);
  localparam logic [15:0] RCD_LOAD  = 16'(T_RCD - 1);
  localparam logic [15:0] RP_LOAD   = 16'(T_RP - 1);
  localparam logic [15:0] RFC_LOAD  = 16'(T_RFC - 1);
  localparam logic [15:0] MRS_LOAD  = 16'd2;
  localparam logic [15:0] REF_LOAD  = 16'(REF_INTERVAL - 1);

  // Burst length 1, sequential, CAS latency in A[6:4]
  localparam logic [8:0] MRS_A = {2'b00, 3'(CAS_LAT), 1'b0, 3'b000};

`ifdef SDRAM_AUTOPRE_EN
  // The READ/WRITE state also covers the precharge time and ends the access.
  localparam logic        RW_AP       = 1'b1;
  localparam logic [15:0] RD_LOAD     = 16'(CAS_LAT + T_RP);
  localparam logic [15:0] WR_LOAD     = 16'(T_WR + T_RP - 1);
  localparam logic [15:0] RD_READY_AT = 16'(T_RP);
`else
  localparam logic        RW_AP       = 1'b0;
  localparam logic [15:0] RD_LOAD     = 16'(CAS_LAT);
  localparam logic [15:0] WR_LOAD     = 16'(T_WR - 1);
  localparam logic [15:0] RD_READY_AT = 16'd0;
`endif
  // READY is registered, so it is set one count before the cycle it shows in
  localparam logic [15:0] RD_READY_PRE = RD_READY_AT + 16'd1;

  typedef enum logic [3:0] {
    ST_RESET, ST_INIT_WAIT, ST_INIT_PRE, ST_INIT_REF1, ST_INIT_REF2,
    ST_INIT_MRS, ST_IDLE, ST_LATCH, ST_ACT, ST_RW, ST_PRE, ST_REF
  } state_t;

  state_t      state_q;
  logic [15:0] cnt_q;
  logic        we_q;
  logic [3:0]  cmd_q;
  logic [8:0]  sd_a_q;
  logic        sd_ap_q;
  logic        lat_g_q;
  logic        lat_oe_n_q;
  logic        ready_q;
  logic        busy_q;
  logic        init_done_q;
  logic [15:0] ref_cnt_q;
  logic        ref_pend_q;

  logic        refresh_due_s;
  logic        decide_s;
  logic        issue_ref_s;

  // Arbitration point: IDLE, or the last wait cycle of a precharge, refresh or
  // auto-precharged access, so that the next command follows without a gap.
  always_comb begin
    refresh_due_s = ref_pend_q | (ref_cnt_q == 16'd0);
    decide_s      = 1'b0;
    case (state_q)
      ST_IDLE:        decide_s = 1'b1;
      ST_PRE, ST_REF: decide_s = (cnt_q == 16'd0);
      ST_RW:          decide_s = RW_AP & (cnt_q == 16'd0);
      default:        decide_s = 1'b0;
    endcase
    issue_ref_s = decide_s & refresh_due_s;
  end

  // Main sequencer FSM with all pin outputs registered alongside the state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_RESET;
      cnt_q       <= 16'd0;
      we_q        <= 1'b0;
      cmd_q       <= CMD_DESEL;
      sd_a_q      <= 9'd0;
      sd_ap_q     <= 1'b0;
      lat_g_q     <= 1'b0;
      lat_oe_n_q  <= 1'b1;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
      init_done_q <= 1'b0;
    end else begin
      cmd_q   <= CMD_NOP;
      sd_ap_q <= 1'b0;
      lat_g_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      if (decide_s) begin
        // Pending refresh always wins over a bus request
        if (refresh_due_s) begin
          state_q <= ST_REF;
          cmd_q   <= CMD_REF;
          cnt_q   <= RFC_LOAD;
        end else if (req_i) begin
          state_q <= ST_LATCH;
          lat_g_q <= 1'b1;
          we_q    <= we_req_i;
        end else begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      end else begin
        case (state_q)
          ST_RESET: begin
            state_q <= ST_INIT_WAIT;
            cnt_q   <= INIT_LOAD;
          end
          ST_INIT_WAIT: begin
            if (cnt_q == 16'd0) begin
              state_q <= ST_INIT_PRE;
              cmd_q   <= CMD_PRE;
              sd_ap_q <= 1'b1;
              cnt_q   <= RP_LOAD;
            end else begin
              cnt_q <= cnt_q - 16'd1;
            end
          end
          ST_INIT_PRE: begin
            if (cnt_q == 16'd0) begin
              state_q <= ST_INIT_REF1;
              cmd_q   <= CMD_REF;
              cnt_q   <= RFC_LOAD;
            end else begin
              cnt_q <= cnt_q - 16'd1;
            end
          end
          ST_INIT_REF1: begin
            if (cnt_q == 16'd0) begin
              state_q <= ST_INIT_REF2;
              cmd_q   <= CMD_REF;
              cnt_q   <= RFC_LOAD;
            end else begin
              cnt_q <= cnt_q - 16'd1;
            end
          end
          ST_INIT_REF2: begin
            if (cnt_q == 16'd0) begin
              state_q <= ST_INIT_MRS;
              cmd_q   <= CMD_MRS;
              sd_a_q  <= MRS_A;
              cnt_q   <= MRS_LOAD;
            end else begin
              cnt_q <= cnt_q - 16'd1;
            end
          end
          ST_INIT_MRS: begin
            if (cnt_q == 16'd0) begin
              state_q     <= ST_IDLE;
              busy_q      <= 1'b0;
              init_done_q <= 1'b1;
              lat_oe_n_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 16'd1;
            end
          end
          ST_LATCH: begin
            state_q <= ST_ACT;
            cmd_q   <= CMD_ACT;
            sd_a_q  <= row_q_i;
            cnt_q   <= RCD_LOAD;
          end
          ST_ACT: begin
            if (cnt_q == 16'd0) begin
              state_q <= ST_RW;
              cmd_q   <= we_q ? CMD_WRITE : CMD_READ;
              sd_a_q  <= col_q_i;
              sd_ap_q <= RW_AP;
              cnt_q   <= we_q ? WR_LOAD : RD_LOAD;
              // A write completes, from the bus point of view, on the WRITE cycle
              ready_q <= we_q;
            end else begin
              cnt_q <= cnt_q - 16'd1;
            end
          end
          ST_RW: begin
            if (cnt_q == 16'd0) begin
              state_q <= ST_PRE;
              cmd_q   <= CMD_PRE;
              sd_ap_q <= 1'b1;
              cnt_q   <= RP_LOAD;
            end else begin
              cnt_q   <= cnt_q - 16'd1;
              ready_q <= ~we_q & (cnt_q == RD_READY_PRE);
            end
          end
          ST_PRE, ST_REF: begin
            cnt_q <= cnt_q - 16'd1;
          end
          default: begin
            state_q <= ST_RESET;
            cmd_q   <= CMD_DESEL;
          end
        endcase
      end
    end
  end

  // Refresh interval counter; a single pending flag absorbs repeated expiries.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ref_cnt_q  <= REF_LOAD;
      ref_pend_q <= 1'b0;
    end else if (init_done_q) begin
      if (ref_cnt_q == 16'd0) begin
        ref_cnt_q <= REF_LOAD;
      end else begin
        ref_cnt_q <= ref_cnt_q - 16'd1;
      end
      // Issuing REF clears the flag, including when it serves this very expiry
      if (issue_ref_s) begin
        ref_pend_q <= 1'b0;
      end else if (ref_cnt_q == 16'd0) begin
        ref_pend_q <= 1'b1;
      end else begin
        ref_pend_q <= ref_pend_q;
      end
    end else begin
      ref_cnt_q  <= ref_cnt_q;
      ref_pend_q <= ref_pend_q;
    end
  end

  assign sd_cs_n_o   = cmd_q[3];
  assign sd_ras_n_o  = cmd_q[2];
  assign sd_cas_n_o  = cmd_q[1];
  assign sd_we_n_o   = cmd_q[0];
  assign sd_a_o      = sd_a_q;
  assign sd_ap_o     = sd_ap_q;
  assign lat_g_o     = lat_g_q;
  assign lat_oe_n_o  = lat_oe_n_q;
  assign ready_o     = ready_q;
  assign busy_o      = busy_q;
  assign init_done_o = init_done_q;

endmodule

// File: tb/tb_sdram_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sdram_cmd_sequencer
//
// Bench for sdram_cmd_sequencer (default build, explicit PRECHARGE).
// Per-cycle vector table covering init, one read and one write, then
// hand-written sequences for refresh priority, refresh during an access
// and reset in the middle of an access.
// ---------------------------------------------------------------------------
module tb_sdram_cmd_sequencer;

  localparam int unsigned INIT_CYCLES  = 8;
  localparam int unsigned REF_INTERVAL = 40;
  localparam int          IDLE_ROW     = 11;
  localparam int          NV           = 32;

  localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD = 4'b0101, C_WR = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010, C_REF = 4'b0001, C_MRS = 4'b0000, C_DES = 4'b1111;

  logic       clk = 1'b0;
  logic       reset, req, we;
  logic [8:0] row, col;
  logic       lat_g, lat_oe_n, cs_n, ras_n, cas_n, we_n, ap, ready, busy, done;
  logic [8:0] sd_a;
  logic [3:0] cmd;

  always #5 clk = ~clk;

  assign cmd = {cs_n, ras_n, cas_n, we_n};

  sdram_cmd_sequencer #(
    .INIT_CYCLES (INIT_CYCLES),
    .REF_INTERVAL(REF_INTERVAL)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .req_i      (req),
    .we_req_i   (we),
    .row_q_i    (row),
    .col_q_i    (col),
    .lat_g_o    (lat_g),
    .lat_oe_n_o (lat_oe_n),
    .sd_cs_n_o  (cs_n),
    .sd_ras_n_o (ras_n),
    .sd_cas_n_o (cas_n),
    .sd_we_n_o  (we_n),
    .sd_a_o     (sd_a),
    .sd_ap_o    (ap),
    .ready_o    (ready),
    .busy_o     (busy),
    .init_done_o(done)
  );

  typedef struct {
    int         n;
    logic       rst, req, we;
    logic [8:0] row, col;
    logic [3:0] cmd;
    logic       a_chk;
    logic [8:0] a;
    logic       ap, lg, oen, rdy, busy, done;
  } vec_t;

  vec_t vecs [NV];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   t0     = 0;

  function automatic vec_t mk(int n, logic rst, logic rq, logic w, logic [8:0] r, logic [8:0] c,
                              logic [3:0] cm, logic achk, logic [8:0] a, logic p, logic lg,
                              logic oen, logic rdy, logic bsy, logic dn);
    vec_t v;
    v.n = n; v.rst = rst; v.req = rq; v.we = w; v.row = r; v.col = c; v.cmd = cm;
    v.a_chk = achk; v.a = a; v.ap = p; v.lg = lg; v.oen = oen; v.rdy = rdy;
    v.busy = bsy; v.done = dn;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cyc %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Drive each row's inputs in the current cycle, compare that cycle's outputs, advance.
  task automatic apply(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        reset = vecs[i].rst; req = vecs[i].req; we = vecs[i].we;
        row = vecs[i].row; col = vecs[i].col;
        if (i == IDLE_ROW && k == 0) t0 = cyc;
        checks++;
        if (cmd !== vecs[i].cmd || (vecs[i].a_chk && sd_a !== vecs[i].a) || ap !== vecs[i].ap ||
            lat_g !== vecs[i].lg || lat_oe_n !== vecs[i].oen || ready !== vecs[i].rdy ||
            busy !== vecs[i].busy || done !== vecs[i].done) begin
          errors++;
          $display("FAIL vec%0d (cyc %0d): got cmd=%b a=%h ap=%b g=%b oe_n=%b rdy=%b busy=%b done=%b, want cmd=%b a=%h ap=%b g=%b oe_n=%b rdy=%b busy=%b done=%b",
                   i, cyc, cmd, sd_a, ap, lat_g, lat_oe_n, ready, busy, done,
                   vecs[i].cmd, vecs[i].a, vecs[i].ap, vecs[i].lg, vecs[i].oen,
                   vecs[i].rdy, vecs[i].busy, vecs[i].done);
        end
        tick();
      end
    end
  endtask

  task automatic wait_until(input int target);
    check("wait_until_not_late", 32'(cyc <= target), 32'd1);
    while (cyc < target) tick();
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy === 1'b1 && k < budget) begin
      tick();
      k++;
    end
    check("wait_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int e, e2, first_ref, nref, rdy_at;
    reset = 1'b1; req = 1'b0; we = 1'b0; row = 9'd0; col = 9'd0;

    //          n  rst rq we row     col     cmd    achk a       ap g  oen rdy bsy dn
    vecs[0]  = mk(1, 1, 0, 0, 9'h000, 9'h000, C_DES, 1, 9'h000, 0, 0, 1, 0, 1, 0);
    vecs[1]  = mk(1, 0, 0, 0, 9'h000, 9'h000, C_DES, 1, 9'h000, 0, 0, 1, 0, 1, 0);
    vecs[2]  = mk(8, 0, 0, 0, 9'h000, 9'h000, C_NOP, 0, 9'h000, 0, 0, 1, 0, 1, 0);
    vecs[3]  = mk(1, 0, 0, 0, 9'h000, 9'h000, C_PRE, 0, 9'h000, 1, 0, 1, 0, 1, 0);
    vecs[4]  = mk(1, 0, 0, 0, 9'h000, 9'h000, C_NOP, 0, 9'h000, 0, 0, 1, 0, 1, 0);
    vecs[5]  = mk(1, 0, 0, 0, 9'h000, 9'h000, C_REF, 0, 9'h000, 0, 0, 1, 0, 1, 0);
    vecs[6]  = mk(6, 0, 0, 0, 9'h000, 9'h000, C_NOP, 0, 9'h000, 0, 0, 1, 0, 1, 0);
    vecs[7]  = mk(1, 0, 0, 0, 9'h000, 9'h000, C_REF, 0, 9'h000, 0, 0, 1, 0, 1, 0);
    vecs[8]  = mk(6, 0, 0, 0, 9'h000, 9'h000, C_NOP, 0, 9'h000, 0, 0, 1, 0, 1, 0);
    vecs[9]  = mk(1, 0, 0, 0, 9'h000, 9'h000, C_MRS, 1, 9'h020, 0, 0, 1, 0, 1, 0);
    vecs[10] = mk(2, 0, 0, 0, 9'h000, 9'h000, C_NOP, 0, 9'h000, 0, 0, 1, 0, 1, 0);
    vecs[11] = mk(1, 0, 0, 0, 9'h000, 9'h000, C_NOP, 0, 9'h000, 0, 0, 0, 0, 0, 1);
    // read: c0..c9
    vecs[12] = mk(1, 0, 1, 0, 9'h1A5, 9'h03C, C_NOP, 0, 9'h000, 0, 0, 0, 0, 0, 1);
    vecs[13] = mk(1, 0, 0, 0, 9'h1A5, 9'h03C, C_NOP, 0, 9'h000, 0, 1, 0, 0, 1, 1);
    vecs[14] = mk(1, 0, 0, 0, 9'h1A5, 9'h03C, C_ACT, 1, 9'h1A5, 0, 0, 0, 0, 1, 1);
    vecs[15] = mk(1, 0, 0, 0, 9'h1A5, 9'h03C, C_NOP, 0, 9'h000, 0, 0, 0, 0, 1, 1);
    vecs[16] = mk(1, 0, 0, 0, 9'h1A5, 9'h03C, C_RD,  1, 9'h03C, 0, 0, 0, 0, 1, 1);
    vecs[17] = mk(1, 0, 0, 0, 9'h1A5, 9'h03C, C_NOP, 0, 9'h000, 0, 0, 0, 0, 1, 1);
    vecs[18] = mk(1, 0, 0, 0, 9'h1A5, 9'h03C, C_NOP, 0, 9'h000, 0, 0, 0, 1, 1, 1);
    vecs[19] = mk(1, 0, 0, 0, 9'h1A5, 9'h03C, C_PRE, 0, 9'h000, 1, 0, 0, 0, 1, 1);
    vecs[20] = mk(1, 0, 0, 0, 9'h1A5, 9'h03C, C_NOP, 0, 9'h000, 0, 0, 0, 0, 1, 1);
    vecs[21] = mk(1, 0, 0, 0, 9'h1A5, 9'h03C, C_NOP, 0, 9'h000, 0, 0, 0, 0, 0, 1);
    // write: c0..c8, then idle
    vecs[22] = mk(1, 0, 1, 1, 9'h0FF, 9'h101, C_NOP, 0, 9'h000, 0, 0, 0, 0, 0, 1);
    vecs[23] = mk(1, 0, 0, 1, 9'h0FF, 9'h101, C_NOP, 0, 9'h000, 0, 1, 0, 0, 1, 1);
    vecs[24] = mk(1, 0, 0, 1, 9'h0FF, 9'h101, C_ACT, 1, 9'h0FF, 0, 0, 0, 0, 1, 1);
    vecs[25] = mk(1, 0, 0, 1, 9'h0FF, 9'h101, C_NOP, 0, 9'h000, 0, 0, 0, 0, 1, 1);
    vecs[26] = mk(1, 0, 0, 1, 9'h0FF, 9'h101, C_WR,  1, 9'h101, 0, 0, 0, 1, 1, 1);
    vecs[27] = mk(1, 0, 0, 1, 9'h0FF, 9'h101, C_NOP, 0, 9'h000, 0, 0, 0, 0, 1, 1);
    vecs[28] = mk(1, 0, 0, 1, 9'h0FF, 9'h101, C_PRE, 0, 9'h000, 1, 0, 0, 0, 1, 1);
    vecs[29] = mk(1, 0, 0, 1, 9'h0FF, 9'h101, C_NOP, 0, 9'h000, 0, 0, 0, 0, 1, 1);
    vecs[30] = mk(1, 0, 0, 0, 9'h0FF, 9'h101, C_NOP, 0, 9'h000, 0, 0, 0, 0, 0, 1);
    vecs[31] = mk(2, 0, 0, 0, 9'h000, 9'h000, C_NOP, 0, 9'h000, 0, 0, 0, 0, 0, 1);

    tick();
    apply(0, NV - 1);

    // Refresh priority: counter reaches 0 in the IDLE cycle where REQ rises
    e = t0 + int'(REF_INTERVAL) - 1;
    wait_until(e);
    req = 1'b1; we = 1'b0; row = 9'h0C3; col = 9'h011;
    check("prio_idle", 32'(busy), 32'd0);
    tick();
    check("prio_ref_first", 32'(cmd), 32'(C_REF));
    for (int k = 0; k < 6; k++) begin
      tick();
      check("prio_no_latch_during_ref", 32'(lat_g), 32'd0);
    end
    tick();
    check("prio_latch_after_trfc", 32'(lat_g), 32'd1);
    req = 1'b0;
    tick();
    check("prio_act", 32'(cmd), 32'(C_ACT));
    check("prio_act_row", 32'(sd_a), 32'h0C3);
    wait_idle(20);

    // Refresh expiry at read c3: REF held off until after the precharge
    e2 = e + int'(REF_INTERVAL);
    wait_until(e2 - 3);
    req = 1'b1; we = 1'b0; row = 9'h055; col = 9'h1AA;
    check("racc_idle", 32'(busy), 32'd0);
    tick();
    check("racc_latch", 32'(lat_g), 32'd1);
    req = 1'b0;
    first_ref = -1; nref = 0; rdy_at = -1;
    for (int k = 2; k <= 20; k++) begin
      tick();
      if (cmd === C_REF) begin
        if (first_ref < 0) first_ref = k;
        nref++;
      end
      if (ready === 1'b1 && rdy_at < 0) rdy_at = k;
      if (k == 7) check("racc_pre_c7", 32'(cmd), 32'(C_PRE));
    end
    check("racc_ref_cycle", 32'(first_ref), 32'd9);
    check("racc_ref_count", 32'(nref), 32'd1);
    check("racc_ready_cycle", 32'(rdy_at), 32'd6);
    check("racc_idle_end", 32'(busy), 32'd0);

    // Reset during the READ cycle: access aborted, full init re-runs
    req = 1'b1; we = 1'b0; row = 9'h1FF; col = 9'h0AA;
    tick();
    req = 1'b0;
    tick();
    tick();
    tick();
    check("rst_read_seen", 32'(cmd), 32'(C_RD));
    reset = 1'b1;
    tick();
    apply(1, IDLE_ROW);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
